// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// multiply/divide sequencer states and the operand forwarding decision.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    // The memory stage holds the younger result, so it wins over writeback.
    // Register 0 is hardwired, so a write to it never forwards.
    function automatic fwd_sel_t fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_wa,
        input logic       m_we,
        input logic [4:0] w_wa,
        input logic       w_we
    );
        if (m_we && (m_wa != 5'd0) && (m_wa == src))
            return FWD_M;
        else if (w_we && (w_wa != 5'd0) && (w_wa == src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_sequencer.sv
// Multiply/divide busy sequencer: IDLE -> BUSY (countdown) -> DONE pulse.
// md_done lands exactly N cycles after the accepted start cycle.
module md_sequencer
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic cancel,
    output logic md_busy,
    output logic md_done,
    output logic md_active,
    output logic md_accept
);

    // The start cycle and the DONE cycle both count toward N, hence the -2.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_accept = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && !cancel) begin
                    md_accept = 1'b1;
                    cnt_nxt   = is_div ? DIV_LOAD : MUL_LOAD;
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt == '0)
                    state_nxt = MD_DONE;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            MD_DONE:  state_nxt = MD_IDLE;
            default:  state_nxt = MD_IDLE;
        endcase
    end

    assign md_busy   = (state == MD_BUSY);
    assign md_done   = (state == MD_DONE);
    assign md_active = (state != MD_IDLE);

`ifndef SYNTHESIS
    // The decode interlock should make a second start while active impossible.
    start_while_active: assert property (@(posedge clock) disable iff (reset)
        !(start && state != MD_IDLE));
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: forwarding selects, stall/flush and md interlock.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/md-op counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_md_op,
    input  logic        d_uses_hilo,
    input  logic [4:0]  e_rs,
    input  logic [4:0]  e_rt,
    input  logic [4:0]  e_wa,
    input  logic        e_rf_we,
    input  logic        e_is_load,
    input  logic        e_md_start,
    input  logic        e_md_is_div,
    input  logic [4:0]  m_wa,
    input  logic        m_rf_we,
    input  logic        m_branch_taken,
    input  logic [4:0]  w_wa,
    input  logic        w_rf_we,
    output logic        f_stall,
    output logic        d_stall,
    output logic        d_flush,
    output logic        e_flush,
    output logic        m_flush,
    output logic [1:0]  e_fwd_a,
    output logic [1:0]  e_fwd_b,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events,
    output logic [31:0] perf_md_ops
`endif
);

    logic md_active;
    logic md_accept;
    logic load_use;
    logic md_ilk;
    logic hazard;

    md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clock     (clock),
        .reset     (reset),
        .start     (e_md_start),
        .is_div    (e_md_is_div),
        .cancel    (m_branch_taken),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_active (md_active),
        .md_accept (md_accept)
    );

    assign e_fwd_a = fwd_sel(e_rs, m_wa, m_rf_we, w_wa, w_rf_we);
    assign e_fwd_b = fwd_sel(e_rt, m_wa, m_rf_we, w_wa, w_rf_we);

    assign load_use = e_is_load && e_rf_we && (e_wa != 5'd0) &&
                      ((e_wa == d_rs) || (e_wa == d_rt));
    // A start still in execute counts as active so the HI/LO user waits a cycle earlier.
    assign md_ilk   = (d_md_op || d_uses_hilo) && (md_active || e_md_start);
    assign hazard   = load_use || md_ilk;

    // A taken branch discards the stalled instructions anyway, so it wins.
    assign f_stall = hazard && !m_branch_taken;
    assign d_stall = hazard && !m_branch_taken;
    assign d_flush = m_branch_taken;
    assign e_flush = hazard || m_branch_taken;
    assign m_flush = m_branch_taken;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
            perf_md_ops       <= '0;
        end else begin
            if (d_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (m_branch_taken && (perf_flush_events != 32'hFFFF_FFFF))
                perf_flush_events <= perf_flush_events + 32'd1;
            if (md_accept && (perf_md_ops != 32'hFFFF_FFFF))
                perf_md_ops <= perf_md_ops + 32'd1;
        end
    end
`endif

endmodule
